// File: rtl/control_unit.sv
// control_unit: hardwired Moore FSM sequencing fetch and execute for the Mini SRC datapath.
// Define CU_SINGLE_STEP_EN to add the step input and a STEP_WAIT state between instructions.
module control_unit #(
  parameter logic [4:0] ALU_INC = 5'b11111,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        stop,
`ifdef CU_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        Pout,
  output logic        MARen,
  output logic        Pen,
  output logic        Read,
  output logic        MDRen,
  output logic        MDROut,
  output logic        IRen,
  output logic        Yen,
  output logic        ZLOen,
  output logic        ZHIen,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIen,
  output logic        LOen,
  output logic        Rin,
  output logic        Rout,
  output logic [3:0]  Gra,
  output logic [3:0]  Grb,
  output logic [3:0]  Grc,
  output logic [1:0]  Gsel,
  output logic [4:0]  alu_control,
  output logic        run
);
  localparam logic [3:0] T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4,
                         T5 = 4'd5, T6 = 4'd6, HALT = 4'd7;
`ifdef CU_SINGLE_STEP_EN
  localparam logic [3:0] STEP_WAIT = 4'd8;
`endif
  logic [3:0] state, nxt, fin;
  logic [4:0] op, code;
  logic is_alu, is_md, ex, t0, t1, t2, t3, t4, t5, t6;
  logic unused_ir;
  assign unused_ir = ^ir[14:0];
  assign is_alu = op inside {[5'b00011:5'b01010]};
  assign is_md = op == 5'b01111 || op == 5'b10000;
  assign ex = is_alu || is_md;
  always_comb begin
    code = 5'b00000;
    case (op)
      5'b00100: code = 5'b00001;
      5'b00101: code = 5'b00111;
      5'b00110: code = 5'b00110;
      5'b00111: code = 5'b01000;
      5'b01000: code = 5'b01001;
      5'b01001: code = 5'b00010;
      5'b01010: code = 5'b00011;
      5'b01111: code = 5'b01100;
      5'b10000: code = 5'b01101;
      default:  code = 5'b00000;
    endcase
  end
`ifdef CU_SINGLE_STEP_EN
  assign fin = stop ? HALT : STEP_WAIT;
`else
  assign fin = stop ? HALT : T0;
`endif
  always_comb begin
    nxt = T0;
    case (state)
      T0:        nxt = T1;
      T1:        nxt = T2;
      T2:        nxt = T3;
      T3:        nxt = op == OP_HALT ? HALT : ex ? T4 : fin;
      T4:        nxt = T5;
      T5:        nxt = is_md ? T6 : fin;
      T6:        nxt = fin;
      HALT:      nxt = HALT;
`ifdef CU_SINGLE_STEP_EN
      STEP_WAIT: nxt = stop ? HALT : step ? T0 : STEP_WAIT;
`endif
      default:   nxt = T0;
    endcase
  end
  // The opcode is captured at the T2->T3 edge so execute decode is independent of later IR changes.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= T0;
      op <= 5'b00000;
    end else begin
      state <= nxt;
      if (state == T2) op <= ir[31:27];
    end
  end
  // Holding clr low forces every control to idle even though the state already reads T0.
  assign t0 = clr && state == T0;
  assign t1 = clr && state == T1;
  assign t2 = clr && state == T2;
  assign t3 = clr && state == T3;
  assign t4 = clr && state == T4;
  assign t5 = clr && state == T5;
  assign t6 = clr && state == T6;
  assign Pout = t0;
  assign MARen = t0;
  assign Pen = t1;
  assign Read = t1;
  assign MDRen = t1;
  assign MDROut = t2;
  assign IRen = t2;
  assign Yen = t3 && ex;
  assign ZLOen = t0 || (t4 && ex);
  assign ZHIen = t4 && is_md;
  assign ZLOout = t1 || (t5 && ex);
  assign ZHIout = t6;
  assign HIen = t6;
  assign LOen = t5 && is_md;
  assign Rin = t5 && is_alu;
  assign Rout = (t3 || t4) && ex;
  assign Gra = ir[26:23];
  assign Grb = ir[22:19];
  assign Grc = ir[18:15];
  assign Gsel = t3 ? (is_alu ? 2'd2 : is_md ? 2'd1 : 2'd0) :
                t4 ? (is_alu ? 2'd3 : is_md ? 2'd2 : 2'd0) :
                t5 && is_alu ? 2'd1 : 2'd0;
  assign alu_control = t0 ? ALU_INC : t4 && ex ? code : 5'b00000;
  assign run = state != HALT;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench for control_unit.
// Honours CU_SINGLE_STEP_EN when the design is built with it.
module tb_control_unit;
  logic clk = 1'b0, clr = 1'b0, stop = 1'b0;
  logic [31:0] ir = 32'h0;
`ifdef CU_SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  logic Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen, ZLOen, ZHIen;
  logic ZLOout, ZHIout, HIen, LOen, Rin, Rout, run;
  logic [3:0] Gra, Grb, Grc;
  logic [1:0] Gsel;
  logic [4:0] alu_control;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop),
`ifdef CU_SINGLE_STEP_EN
    .step(step),
`endif
    .Pout(Pout), .MARen(MARen), .Pen(Pen), .Read(Read), .MDRen(MDRen),
    .MDROut(MDROut), .IRen(IRen), .Yen(Yen), .ZLOen(ZLOen), .ZHIen(ZHIen),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .HIen(HIen), .LOen(LOen), .Rin(Rin),
    .Rout(Rout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Gsel(Gsel),
    .alu_control(alu_control), .run(run)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] s;
    logic [1:0]  gsel;
    logic [4:0]  alu;
    logic        run;
    logic [11:0] g;
  } obs_t;

  localparam logic [15:0] M_POUT = 16'h0001, M_MAREN = 16'h0002, M_PEN = 16'h0004,
    M_READ = 16'h0008, M_MDREN = 16'h0010, M_MDROUT = 16'h0020, M_IREN = 16'h0040,
    M_YEN = 16'h0080, M_ZLOEN = 16'h0100, M_ZHIEN = 16'h0200, M_ZLOOUT = 16'h0400,
    M_ZHIOUT = 16'h0800, M_HIEN = 16'h1000, M_LOEN = 16'h2000, M_RIN = 16'h4000,
    M_ROUT = 16'h8000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  obs_t sb[$];
  int n_chk = 0, n_fail = 0, sw_len = 10;
  logic [4:0] alu_tab [8] = '{5'b00000, 5'b00001, 5'b00111, 5'b00110,
                              5'b01000, 5'b01001, 5'b00010, 5'b00011};

  function automatic obs_t observe();
    obs_t o;
    o.s = {Rout, Rin, LOen, HIen, ZHIout, ZLOout, ZHIen, ZLOen, Yen, IRen,
           MDROut, MDRen, Read, Pen, MARen, Pout};
    o.gsel = Gsel;
    o.alu = alu_control;
    o.run = run;
    o.g = {Gra, Grb, Grc};
    return o;
  endfunction

  // Instruction class from the opcode: 1 = two-operand ALU op, 2 = mul/div, 0 = no-op.
  function automatic int kind_of(logic [4:0] op);
    int o = int'(op);
    return (o >= 3 && o <= 10) ? 1 : (o == 15 || o == 16) ? 2 : 0;
  endfunction

  function automatic logic [4:0] code_of(logic [4:0] op);
    int o = int'(op);
    return kind_of(op) == 1 ? alu_tab[o - 3] : 5'(12 + o - 15);
  endfunction

  function automatic int len_of(logic [4:0] op);
    return kind_of(op) == 1 ? 6 : kind_of(op) == 2 ? 7 : 4;
  endfunction

  function automatic obs_t idle(logic [31:0] v, logic r);
    obs_t e;
    e.s = '0;
    e.gsel = 2'd0;
    e.alu = 5'd0;
    e.run = r;
    e.g = v[26:15];
    return e;
  endfunction

  function automatic obs_t exp_cycle(logic [31:0] v, int c);
    obs_t e = idle(v, 1'b1);
    int k = kind_of(v[31:27]);
    case (c)
      0: begin e.s = M_POUT | M_MAREN | M_ZLOEN; e.alu = 5'b11111; end
      1: e.s = M_ZLOOUT | M_PEN | M_READ | M_MDREN;
      2: e.s = M_MDROUT | M_IREN;
      3: if (k != 0) begin e.s = M_ROUT | M_YEN; e.gsel = k == 1 ? 2'd2 : 2'd1; end
      4: begin
        e.s = k == 1 ? (M_ROUT | M_ZLOEN) : (M_ROUT | M_ZLOEN | M_ZHIEN);
        e.gsel = k == 1 ? 2'd3 : 2'd2;
        e.alu = code_of(v[31:27]);
      end
      5: if (k == 1) begin e.s = M_ZLOOUT | M_RIN; e.gsel = 2'd1; end
         else e.s = M_ZLOOUT | M_LOEN;
      default: e.s = M_ZHIOUT | M_HIEN;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got s=%h gsel=%0d alu=%b run=%b g=%h, expected s=%h gsel=%0d alu=%b run=%b g=%h",
               name, $time, got.s, got.gsel, got.alu, got.run, got.g,
               exp.s, exp.gsel, exp.alu, exp.run, exp.g);
    end
  endtask

  initial begin
    obs_t e, o;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        o = observe();
        check("cycle", o, e);
        n_chk++;
        if ($countones({Pout, MDROut, ZLOout, ZHIout, Rout}) > 1) begin
          n_fail++;
          $display("FAIL bus_drivers @%0t: got %0d drivers, expected at most 1", $time,
                   $countones({Pout, MDROut, ZLOout, ZHIout, Rout}));
        end
      end
    end
  end

  task automatic step_wait(input int n);
`ifdef CU_SINGLE_STEP_EN
    for (int i = 0; i < n; i++) sb.push_back(idle(ir, 1'b1));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == n - 1) step = 1'b1;
    end
`else
    if (n < 0) $display("step_wait ignored");
`endif
  endtask

  task automatic run_instr(input logic [31:0] v, input int stop_at, input int abort,
                           input logic from_rst);
    int n = abort > 0 ? abort : len_of(v[31:27]);
    int first = from_rst ? 1 : 0;
    ir = v;
    if (from_rst) begin
      clr = 1'b1;
      #1 check("release_t0", observe(), exp_cycle(v, 0));
    end
    for (int c = first; c < n; c++) sb.push_back(exp_cycle(v, c));
    for (int c = first; c < n; c++) begin
      @(negedge clk);
`ifdef CU_SINGLE_STEP_EN
      step = 1'b0;
`endif
      if (c == stop_at) stop = 1'b1;
    end
    if (abort == 0 && stop_at < 0 && v[31:27] != OP_HALT) step_wait(sw_len);
  endtask

  task automatic halt_wait(input int n);
    for (int i = 0; i < n; i++) sb.push_back(idle(ir, 1'b0));
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_for(input int n);
    clr = 1'b0;
    stop = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    step = 1'b0;
`endif
    #1 check("async_reset", observe(), idle(ir, 1'b1));
    for (int i = 0; i < n; i++) sb.push_back(idle(ir, 1'b1));
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [4:0] op;
    logic fr;
    int stp;
    @(negedge clk);
    reset_for(3);
    run_instr(32'h28918000, -1, 0, 1'b1);
    sw_len = 2;
    run_instr({5'b01111, 4'd1, 4'd2, 4'd0, 15'h0}, -1, 0, 1'b0);
    run_instr({5'b10111, 27'h2a5c3e1}, -1, 0, 1'b0);
    run_instr({5'b00011, 4'd3, 4'd4, 4'd5, 15'h0}, 4, 0, 1'b0);
    halt_wait(20);
    reset_for(2);
    run_instr({OP_HALT, 27'h0}, -1, 0, 1'b1);
    halt_wait(20);
    reset_for(2);
    run_instr({5'b00100, 4'd6, 4'd7, 4'd8, 15'h0}, -1, 5, 1'b1);
    reset_for(2);
    fr = 1'b1;
    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom_range(0, 31));
      v = $urandom;
      v[31:27] = op;
      stp = $urandom_range(0, 15) == 0 ? $urandom_range(1, len_of(op) - 1) : -1;
      sw_len = $urandom_range(1, 3);
      run_instr(v, stp, 0, fr);
      if (stp >= 0 || op == OP_HALT) begin
        halt_wait(3);
        reset_for(1);
        fr = 1'b1;
      end else fr = 1'b0;
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
